// File: rtl/dot_result_pkg.sv
// Shared types and helpers for the mem3 result read-out path.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: FSM state encoding, skid FIFO depth, wrapping address increment.
package dot_result_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The skid buffer logic uses 1-bit pointers, so this must stay 2.
    localparam int FIFO_DEPTH = 2;

    // Address + 1, wrapped to a 2**width address space.
    function automatic logic [31:0] addr_inc(input logic [31:0] addr, input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (addr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs mem3 read data ahead of the output port.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: none internally; the caller never pushes into a full FIFO unless it also pops.
// Ports: clk, rst (async active-high), push/push_data, pop, head (oldest word), count (0..2).
module result_skid_fifo
    import dot_result_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        // Push into a full FIFO is only accepted together with a pop; the
        // write then lands in the slot the head is leaving this cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/dot_result_reader.sv
// Reads a programmable run of words from mem3 and streams them out with a last marker.
// Latency: start edge E0 -> mem_rd_en in next cycle -> data captured at E2 -> m_valid after E2.
// Backpressure: reads are issued only while FIFO + in-flight stays within 2, so m_ready stalls never lose data.
// Ports: start/base_addr/count request a run; mem_rd_* drive mem3's sync read port;
//        m_valid/m_ready/m_data/m_last form the output stream; busy/done/start_ignored report status.
module dot_result_reader #(
    parameter int DATA_WIDTH      = 8,
    parameter int MEM3_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MEM3_ADDR_WIDTH-1:0] base_addr,
    input  logic [MEM3_ADDR_WIDTH:0]   count,
    output logic                       mem_rd_en,
    output logic [MEM3_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]      mem_rd_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done,
    output logic                       start_ignored
);

    import dot_result_pkg::*;

    state_t                     state_q, state_d;
    logic [MEM3_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [MEM3_ADDR_WIDTH:0]   remaining_issue_q, remaining_issue_d;
    logic [MEM3_ADDR_WIDTH:0]   remaining_out_q, remaining_out_d;
    logic                       inflight_q, inflight_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       start_ignored_q, start_ignored_d;

    logic [1:0]                 fifo_count;
    logic [DATA_WIDTH-1:0]      fifo_head;
    logic                       pop;
    logic                       issue;
    logic [2:0]                 occupancy;

    result_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        pop = (fifo_count != 2'd0) && m_ready;
        // Occupancy after this edge: a pop frees a slot in time for a new read,
        // which is what keeps the stream bubble-free with m_ready held high.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == READ) && (remaining_issue_q != '0) && (occupancy < 3'(FIFO_DEPTH));

        state_d           = state_q;
        rd_ptr_d          = rd_ptr_q;
        remaining_issue_d = remaining_issue_q;
        remaining_out_d   = remaining_out_q;
        inflight_d        = issue;

        if (pop && (remaining_out_q != '0)) begin
            remaining_out_d = remaining_out_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_ptr_d          = base_addr;
                    remaining_issue_d = count;
                    remaining_out_d   = count;
                    state_d           = (count == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    rd_ptr_d          = MEM3_ADDR_WIDTH'(addr_inc(32'(rd_ptr_q), MEM3_ADDR_WIDTH));
                    remaining_issue_d = remaining_issue_q - 1'b1;
                    if (remaining_issue_q == 1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (remaining_out_q == 1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d          = (state_d == READ) || (state_d == DRAIN);
        done_d          = (state_d == DONE);
        // Anything other than IDLE (including the DONE cycle) counts as busy.
        start_ignored_d = start && (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            rd_ptr_q          <= '0;
            remaining_issue_q <= '0;
            remaining_out_q   <= '0;
            inflight_q        <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            start_ignored_q   <= 1'b0;
        end else begin
            state_q           <= state_d;
            rd_ptr_q          <= rd_ptr_d;
            remaining_issue_q <= remaining_issue_d;
            remaining_out_q   <= remaining_out_d;
            inflight_q        <= inflight_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            start_ignored_q   <= start_ignored_d;
        end
    end

    assign mem_rd_en     = issue;
    assign mem_rd_addr   = rd_ptr_q;
    assign m_valid       = (fifo_count != 2'd0);
    assign m_data        = fifo_head;
    assign m_last        = m_valid && (remaining_out_q == 1);
    assign busy          = busy_q;
    assign done          = done_q;
    assign start_ignored = start_ignored_q;

endmodule

// File: tb/tb_dot_result_reader.sv
// Bench for dot_result_reader: mem3 model, directed scenarios with random data/backpressure.
// Latency: not applicable.
// Backpressure: m_ready driven per scenario (always high, fixed toggle pattern, or random).
module tb_dot_result_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          start_ignored;

    logic [DW-1:0] mem3 [NW];

    int n_assert;
    int n_fail;

    dot_result_reader #(
        .DATA_WIDTH      (DW),
        .MEM3_ADDR_WIDTH (AW),
        .FIFO_DEPTH      (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done),
        .start_ignored (start_ignored)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem3 synchronous read port: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem3[mem_rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".mem_rd_en"},     32'(mem_rd_en),     32'd0);
        chk({tag, ".mem_rd_addr"},   32'(mem_rd_addr),   32'd0);
        chk({tag, ".m_valid"},       32'(m_valid),       32'd0);
        chk({tag, ".m_data"},        32'(m_data),        32'd0);
        chk({tag, ".m_last"},        32'(m_last),        32'd0);
        chk({tag, ".busy"},          32'(busy),          32'd0);
        chk({tag, ".done"},          32'(done),          32'd0);
        chk({tag, ".start_ignored"}, 32'(start_ignored), 32'd0);
    endtask

    task automatic fill_random_mem();
        for (int i = 0; i < NW; i++) begin
            mem3[i] = DW'($urandom_range(0, 255));
        end
    endtask

    // One complete run. mode 0: m_ready always 1; 1: pattern 1,0,0,1,0,1,...; 2: random.
    // dup_at > 0 pulses a second start in that sample cycle (it must be ignored).
    task automatic do_run(input int base, input int cnt, input int mode, input int dup_at);
        int            pat [6] = '{1, 0, 0, 1, 0, 1};
        logic [DW-1:0] exp_q [$];
        int            issued;
        int            accepted;
        int            last_hs_cyc;
        int            done_seen;
        int            done_cyc;
        int            ign_seen;
        int            cyc;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic          hs;

        exp_q = {};
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(mem3[(base + i) % NW]);
        end
        issued      = 0;
        accepted    = 0;
        last_hs_cyc = 0;
        done_seen   = 0;
        done_cyc    = 0;
        ign_seen    = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(base);
        count     = (AW + 1)'(cnt);
        m_ready   = 1'b1;

        cyc = 1;
        while (cyc < 400 && !(done_seen != 0 && cyc > done_cyc + 2)) begin
            @(negedge clk);
            start = (cyc == dup_at);
            if (cyc == 1 || cyc == dup_at) begin
                // Scramble run parameters: the DUT must use the latched values.
                base_addr = AW'($urandom_range(0, NW - 1));
                count     = (AW + 1)'($urandom_range(0, NW));
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[(cyc - 1) % 6] != 0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;

            chk("start_ignored", 32'(start_ignored), 32'(dup_at > 0 && cyc == dup_at + 1));
            if (start_ignored) ign_seen++;

            if (prev_stall) begin
                chk("stall.valid", 32'(m_valid), 32'd1);
                chk("stall.data",  32'(m_data),  32'(prev_data));
                chk("stall.last",  32'(m_last),  32'(prev_last));
            end

            if (done_seen == 0) begin
                chk("busy", 32'(busy), 32'(!done));
                if (mode == 0) begin
                    chk("thru.rd_en", 32'(mem_rd_en), 32'(cyc >= 1 && cyc < 1 + cnt));
                    chk("thru.valid", 32'(m_valid),   32'(cyc >= 3 && cyc < 3 + cnt));
                end
                if (done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                    chk("done.timing", 32'(cyc),      32'(last_hs_cyc + 1));
                    chk("done.count",  32'(accepted), 32'(cnt));
                end
            end else begin
                chk("post.done",  32'(done),      32'd0);
                chk("post.busy",  32'(busy),      32'd0);
                chk("post.valid", 32'(m_valid),   32'd0);
                chk("post.rd_en", 32'(mem_rd_en), 32'd0);
            end

            if (mem_rd_en) begin
                chk("rd.in_range", 32'(issued < cnt), 32'd1);
                chk("rd.addr", 32'(mem_rd_addr), 32'((base + issued) % NW));
                issued++;
            end

            hs = m_valid && m_ready;
            if (m_valid) begin
                chk("m_last", 32'(m_last), 32'(accepted == cnt - 1));
            end
            if (hs) begin
                chk("m_data", 32'(m_data), (accepted < cnt) ? 32'(exp_q[accepted]) : 32'hDEAD);
                accepted++;
                last_hs_cyc = cyc;
            end
            chk("occupancy", 32'(issued - accepted <= 2), 32'd1);

            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            cyc++;
        end
        start = 1'b0;

        chk("run.completed", 32'(done_seen), 32'd1);
        chk("run.accepted",  32'(accepted),  32'(cnt));
        chk("run.ignored",   32'(ign_seen),  32'(dup_at > 0));
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        m_ready   = 1'b0;
        fill_random_mem();

        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed data, full throughput, latency and last marker.
        mem3[0] = 8'd10; mem3[1] = 8'd20; mem3[2] = 8'd30; mem3[3] = 8'd40;
        do_run(0, 4, 0, 0);

        // Address wrap 14,15,0.
        mem3[14] = 8'd7; mem3[15] = 8'd8; mem3[0] = 8'd9;
        do_run(14, 3, 0, 0);

        // Toggling backpressure.
        fill_random_mem();
        do_run(5, 4, 1, 0);

        // Empty run, with a start landing in the DONE cycle.
        do_run(3, 0, 0, 1);

        // Second start while busy.
        fill_random_mem();
        do_run(9, 4, 0, 3);

        // Whole address space from a random base under random backpressure.
        fill_random_mem();
        do_run($urandom_range(0, NW - 1), NW, 2, 0);

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            fill_random_mem();
            do_run($urandom_range(0, NW - 1), $urandom_range(0, NW), (r % 2 == 0) ? 2 : 1,
                   (r % 3 == 0) ? 2 : 0);
        end

        // Reset after two words of a four-word run.
        fill_random_mem();
        @(negedge clk);
        start = 1'b1; base_addr = '0; count = 5'd4; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rstrun.word0", 32'(m_data), 32'(mem3[0]));
        @(negedge clk); #1;
        chk("rstrun.word1", 32'(m_data), 32'(mem3[1]));
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrun_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_hold.done", 32'(done), 32'd0);
            chk("rst_hold.valid", 32'(m_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        do_run(0, 1, 0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_result_reader.md
Name: dot_result_reader

Overview:
- Read-side counterpart of the dot-product result writer.
- After the writer has filled the result memory (mem3), this block reads a programmable run of result words from mem3's synchronous read port.
- It streams the words out on a valid/ready interface with a last marker.
- It sits between mem3 and the host/output logic, replacing direct read_en/read_addr polling of result_out.

Parameters:
DATA_WIDTH, 8, width of one stored result word (low byte of the dot product)
MEM3_ADDR_WIDTH, 4, mem3 address width; address space 2**MEM3_ADDR_WIDTH words
FIFO_DEPTH, 2, output skid buffer depth; fixed at 2, other values unsupported

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a read run
base_addr  input  MEM3_ADDR_WIDTH  first mem3 address, sampled with start
count  input  MEM3_ADDR_WIDTH+1  number of words to read, sampled with start, 0..2**MEM3_ADDR_WIDTH
mem_rd_en  output  1  mem3 read enable
mem_rd_addr  output  MEM3_ADDR_WIDTH  mem3 read address
mem_rd_data  input  DATA_WIDTH  mem3 read data, valid the cycle after mem_rd_en
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts word
m_data  output  DATA_WIDTH  output word
m_last  output  1  marks final word of the run, qualified by m_valid
busy  output  1  run in progress
done  output  1  one-cycle pulse at run completion
start_ignored  output  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset: async on rst=1; state IDLE; FIFO emptied; any in-flight read is discarded.
  - All outputs 0: mem_rd_en, mem_rd_addr, m_valid, m_data, m_last, busy, done, start_ignored.
  - Reset mid-run drops the run entirely; no done pulse.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr into rd_ptr, count into remaining_issue and remaining_out.
  - count=0 -> DONE, no memory access.
  - count>0 -> READ.
- READ:
  - mem_rd_en = issue condition: remaining_issue>0 and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
  - mem_rd_addr = rd_ptr.
  - Each issue increments rd_ptr modulo 2**MEM3_ADDR_WIDTH (wraps 15->0 at default width) and decrements remaining_issue.
  - inflight is a 1-bit register set on issue; the next cycle mem_rd_data is pushed into the FIFO.
  - Go to DRAIN when remaining_issue reaches 0.
- DRAIN:
  - No further reads.
  - Go to DONE on the handshake of the final word (remaining_out 1->0).
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- busy=1 in READ and DRAIN.
- Output stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last = m_valid and remaining_out==1.
  - m_data/m_last hold stable while m_valid=1 and m_ready=0.
  - remaining_out decrements on each handshake.
- Latency: start sampled at edge E0; mem_rd_en high in the cycle after E0; data captured at E2; m_valid high after E2.
- Throughput: one word per cycle with m_ready held high; no bubbles after the first word.
- Backpressure: FIFO plus in-flight never exceeds 2 entries; no data lost or duplicated.
- Simultaneous push and pop on a full FIFO is legal; occupancy stays constant.
- start while busy: ignored, start_ignored pulses, run continues unaffected.
- start in the DONE cycle is treated as busy and ignored.
- count > 2**MEM3_ADDR_WIDTH is not representable. count = 2**MEM3_ADDR_WIDTH reads every word once, starting at base_addr and wrapping.

Decomposition:
- Package dot_result_pkg:
  - state enum (IDLE, READ, DRAIN, DONE);
  - FIFO_DEPTH constant;
  - a function for modulo address increment.
- Sub-module result_skid_fifo: 2-entry synchronous FIFO with push, pop, head, count, async active-high rst.
- Top holds the FSM, pointers and counters.

Test Plan:
- mem3[0..3]=10,20,30,40; start base=0 count=4, m_ready=1 -> m_valid high 2 cycles after start; m_data 10,20,30,40 on consecutive cycles; m_last with 40; done one cycle after last handshake.
- mem3[14]=7, mem3[15]=8, mem3[0]=9; base=14 count=3 -> mem_rd_addr 14,15,0; data 7,8,9.
- count=4, m_ready toggling 1,0,0,1,0,1,... -> each word delivered exactly once in order; data held stable while stalled; FIFO occupancy never exceeds 2.
- count=0 -> no mem_rd_en, no m_valid; done pulses the cycle after start.
- Second start during a count=4 run -> start_ignored pulses once; first run completes unchanged.
- Assert rst after 2 words of a count=4 run -> all outputs 0 immediately; no done; a fresh start base=0 count=1 then returns mem3[0].
